// File: rtl/ring_evt_pkg.sv
// Shared types, defaults and helpers for the ring event buffer.
// Pointers are absolute; differences are taken modulo 2^pw.
package ring_evt_pkg;

  localparam int DW_DEF       = 12;
  localparam int TAG_W_DEF    = 6;
  localparam int AW_DEF       = 12;
  localparam int INFO_W_DEF   = 36;
  localparam int SAMP_W_DEF   = 7;
  localparam int L1Q_AW_DEF   = 4;
  localparam int WARN_LVL_DEF = 3328;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } rd_state_e;

  // RDATA layout: {ovr, tag, data}
  function automatic int rdata_tag_lsb(input int dw);
    return dw;
  endfunction

  function automatic int rdata_ovr_bit(input int dw, input int tag_w);
    return dw + tag_w;
  endfunction

  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int pw);
    return (a - b) & ((32'd1 << pw) - 32'd1);
  endfunction

endpackage

// File: rtl/ring_evt_buf_l1a_queue.sv
// Synchronous show-ahead FIFO holding {start pointer, L1A info} per trigger.
// A push into a full queue is accepted only when a pop frees a slot the same cycle.
module l1a_queue #(
  parameter int AW = 4,
  parameter int W  = 49
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  assign count = wp - rp;
  assign full  = count[AW];
  assign empty = (count == '0);
  assign dout  = mem[rp[AW-1:0]];

endmodule

// File: rtl/ring_evt_buf.sv
// Circular sample buffer with L1A-triggered readout of pre/post-trigger windows
// into a back-pressured event buffer.
//
// state | meaning
// IDLE  | wait for a queued L1A and downstream room
// LOAD  | pop queue, emit header, set read pointer to event start
// READ  | issue SAMP_MAX ring reads, stalling on almost-full or empty ring
module ring_evt_buf
  import ring_evt_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int AW       = AW_DEF,
  parameter int INFO_W   = INFO_W_DEF,
  parameter int SAMP_W   = SAMP_W_DEF,
  parameter int L1Q_AW   = L1Q_AW_DEF,
  parameter int WARN_LVL = WARN_LVL_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_RESYNC,
  input  logic [SAMP_W-1:0]     SAMP_MAX,
  input  logic [AW-1:0]         PRE_SAMP,
  input  logic [DW-1:0]         WDATA,
  input  logic [TAG_W-1:0]      WTAG,
  input  logic                  WREN,
  input  logic                  L1A_WRT_EN,
  input  logic [INFO_W-1:0]     L1A_INFO,
  input  logic                  EVT_BUF_AFL,
  output logic [INFO_W-1:0]     L1A_EVT_DATA,
  output logic                  L1A_EVT_PUSH,
  output logic [TAG_W+DW:0]     RDATA,
  output logic                  DATA_PUSH,
  output logic [AW:0]           RING_CNT,
  output logic                  WARN,
  output logic                  OVERRUN,
  output logic [7:0]            L1A_DROP,
  output logic [L1Q_AW:0]       L1A_PEND
);

  localparam int PW      = AW + 1;
  localparam int QW      = PW + INFO_W;
  localparam int RW      = TAG_W + DW;
  localparam int OVR_BIT = rdata_ovr_bit(DW, TAG_W);

  rd_state_e          state, state_nx;
  logic [PW-1:0]      wr_ptr, rd_ptr, rd_lag, fill;
  logic [SAMP_W-1:0]  cnt, samp_lat;
  logic               issue;

  logic               q_pop, q_full, q_empty;
  logic [QW-1:0]      q_din, q_dout;
  logic [PW-1:0]      head_start;
  logic [INFO_W-1:0]  head_info;

  logic [RW-1:0]      mem [2**AW];
  logic [RW-1:0]      rd_q;
  logic               rd_vld, rd_ovr;

  assign q_din = {wr_ptr - PW'(PRE_SAMP), L1A_INFO};
  assign q_pop = (state == ST_LOAD);
  assign {head_start, head_info} = q_dout;

  l1a_queue #(.AW(L1Q_AW), .W(QW)) u_l1a_queue (
    .clk_sys (CLK),
    .rst     (RST_RESYNC),
    .push    (L1A_WRT_EN),
    .pop     (q_pop),
    .din     (q_din),
    .dout    (q_dout),
    .full    (q_full),
    .empty   (q_empty),
    .count   (L1A_PEND)
  );

  always_ff @(posedge CLK) begin
    if (RST_RESYNC) wr_ptr <= '0;
    else if (WREN)  wr_ptr <= wr_ptr + PW'(1);
  end

  // Read-first: a read that shares an address with this cycle's write sees the old word.
  always_ff @(posedge CLK) begin
    if (WREN)  mem[wr_ptr[AW-1:0]] <= {WTAG, WDATA};
    if (issue) rd_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (RST_RESYNC) begin
      state    <= ST_IDLE;
      rd_ptr   <= '0;
      cnt      <= '0;
      samp_lat <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_LOAD) begin
        rd_ptr   <= head_start;
        cnt      <= '0;
        samp_lat <= SAMP_MAX;
      end else if (issue) begin
        rd_ptr <= rd_ptr + PW'(1);
        cnt    <= cnt + SAMP_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      ST_IDLE: if (!q_empty && !EVT_BUF_AFL) state_nx = ST_LOAD;
      ST_LOAD: state_nx = (SAMP_MAX == '0) ? ST_IDLE : ST_READ;
      ST_READ: begin
        if (!EVT_BUF_AFL && (rd_ptr != wr_ptr)) begin
          issue = 1'b1;
          if (cnt + SAMP_W'(1) == samp_lat) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rd_lag = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));

  always_ff @(posedge CLK) begin
    if (RST_RESYNC) begin
      rd_vld    <= 1'b0;
      rd_ovr    <= 1'b0;
      DATA_PUSH <= 1'b0;
      RDATA     <= '0;
      OVERRUN   <= 1'b0;
    end else begin
      rd_vld    <= issue;
      rd_ovr    <= issue && (rd_lag > {1'b1, {AW{1'b0}}});
      DATA_PUSH <= rd_vld;
      if (rd_vld) begin
        RDATA[OVR_BIT]     <= rd_ovr;
        RDATA[OVR_BIT-1:0] <= rd_q;
      end
      if (rd_vld && rd_ovr) OVERRUN <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_RESYNC) L1A_DROP <= '0;
    else if (L1A_WRT_EN && q_full && !q_pop && (L1A_DROP != 8'hFF))
      L1A_DROP <= L1A_DROP + 8'd1;
  end

  assign L1A_EVT_PUSH = (state == ST_LOAD);
  assign L1A_EVT_DATA = L1A_EVT_PUSH ? head_info : '0;

  // Occupancy is measured from the oldest sample still needed by a pending event.
  always_comb begin
    fill = '0;
    if (state == ST_READ) fill = rd_lag;
    else if (!q_empty)    fill = PW'(ptr_diff(32'(wr_ptr), 32'(head_start), PW));
  end

  assign RING_CNT = fill;
  assign WARN     = (int'(fill) > WARN_LVL);

endmodule

// File: tb/tb_ring_evt_buf.sv
// Randomised bench for ring_evt_buf: an absolute-index sample history serves as
// the reference for every read word, its overwrite flag and the event timing.
module tb_ring_evt_buf;

  localparam int DW     = 12;
  localparam int TAG_W  = 6;
  localparam int AW     = 12;
  localparam int INFO_W = 36;
  localparam int SAMP_W = 7;
  localparam int L1Q_AW = 4;
  localparam int DEPTH  = 4096;

  logic                CLK = 1'b0;
  logic                RST_RESYNC;
  logic [SAMP_W-1:0]   SAMP_MAX;
  logic [AW-1:0]       PRE_SAMP;
  logic [DW-1:0]       WDATA;
  logic [TAG_W-1:0]    WTAG;
  logic                WREN;
  logic                L1A_WRT_EN;
  logic [INFO_W-1:0]   L1A_INFO;
  logic                EVT_BUF_AFL;
  logic [INFO_W-1:0]   L1A_EVT_DATA;
  logic                L1A_EVT_PUSH;
  logic [TAG_W+DW:0]   RDATA;
  logic                DATA_PUSH;
  logic [AW:0]         RING_CNT;
  logic                WARN;
  logic                OVERRUN;
  logic [7:0]          L1A_DROP;
  logic [L1Q_AW:0]     L1A_PEND;

  ring_evt_buf #(.DW(DW), .TAG_W(TAG_W), .AW(AW), .INFO_W(INFO_W), .SAMP_W(SAMP_W),
                 .L1Q_AW(L1Q_AW), .WARN_LVL(3328)) dut (
    .CLK(CLK), .RST_RESYNC(RST_RESYNC), .SAMP_MAX(SAMP_MAX), .PRE_SAMP(PRE_SAMP),
    .WDATA(WDATA), .WTAG(WTAG), .WREN(WREN), .L1A_WRT_EN(L1A_WRT_EN),
    .L1A_INFO(L1A_INFO), .EVT_BUF_AFL(EVT_BUF_AFL), .L1A_EVT_DATA(L1A_EVT_DATA),
    .L1A_EVT_PUSH(L1A_EVT_PUSH), .RDATA(RDATA), .DATA_PUSH(DATA_PUSH),
    .RING_CNT(RING_CNT), .WARN(WARN), .OVERRUN(OVERRUN), .L1A_DROP(L1A_DROP),
    .L1A_PEND(L1A_PEND)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [TAG_W+DW:0] rdata; int cyc; int w; } dword_t;
  typedef struct { logic [INFO_W-1:0] info; int cyc; } hword_t;

  dword_t dat_q[$];
  hword_t hdr_q[$];
  logic [TAG_W+DW-1:0] hist [int];
  int cyc = 0, wcount = 0, wr_d1 = 0, wr_d2 = 0, l1a_cyc = 0;
  int n_chk = 0, n_fail = 0;
  logic wr_on = 1'b0;

  // Observer: logs pushes and keeps the absolute write count / sample history.
  always @(negedge CLK) begin
    cyc++;
    if (DATA_PUSH)    dat_q.push_back('{RDATA, cyc, wr_d2});
    if (L1A_EVT_PUSH) hdr_q.push_back('{L1A_EVT_DATA, cyc});
    if (L1A_WRT_EN)   l1a_cyc = cyc;
    wr_d2 = wr_d1;
    wr_d1 = wcount;
    if (RST_RESYNC) wcount = 0;
    else if (WREN) begin
      hist[wcount] = {WTAG, WDATA};
      wcount++;
    end
  end

  // Word n read while wr count is w: newest sample at that RAM slot, flagged if lapped.
  function automatic logic [TAG_W+DW:0] exp_word(input int n, input int w);
    int m;
    logic ov;
    ov = (w - n) > DEPTH;
    m  = n + DEPTH * ((w - 1 - n) / DEPTH);
    return {ov, hist[m]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    WREN       = wr_on;
    WDATA      = DW'($urandom);
    WTAG       = TAG_W'($urandom);
    L1A_WRT_EN = 1'b0;
  endtask

  function automatic logic [INFO_W-1:0] rnd_info();
    return INFO_W'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    RST_RESYNC = 1'b1; SAMP_MAX = '0; PRE_SAMP = '0; EVT_BUF_AFL = 1'b0;
    L1A_INFO = '0; wr_on = 1'b0;
    repeat (3) tick();
    n_chk++; if (L1A_EVT_DATA !== '0) begin n_fail++; $display("FAIL rst_evt_data got %h exp 0", L1A_EVT_DATA); end
    n_chk++; if (L1A_EVT_PUSH !== 1'b0) begin n_fail++; $display("FAIL rst_evt_push got %b exp 0", L1A_EVT_PUSH); end
    n_chk++; if (RDATA !== '0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", RDATA); end
    n_chk++; if (DATA_PUSH !== 1'b0) begin n_fail++; $display("FAIL rst_data_push got %b exp 0", DATA_PUSH); end
    n_chk++; if (RING_CNT !== '0) begin n_fail++; $display("FAIL rst_ring_cnt got %0d exp 0", RING_CNT); end
    n_chk++; if (WARN !== 1'b0) begin n_fail++; $display("FAIL rst_warn got %b exp 0", WARN); end
    n_chk++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b exp 0", OVERRUN); end
    n_chk++; if (L1A_DROP !== '0) begin n_fail++; $display("FAIL rst_drop got %0d exp 0", L1A_DROP); end
    n_chk++; if (L1A_PEND !== '0) begin n_fail++; $display("FAIL rst_pend got %0d exp 0", L1A_PEND); end
    RST_RESYNC = 1'b0;
    tick();
    hdr_q.delete(); dat_q.delete();
  endtask

  task automatic test_basic();
    logic [INFO_W-1:0] info;
    int hc;
    PRE_SAMP = 12'd4; SAMP_MAX = 7'd8; wr_on = 1'b1;
    for (int i = 0; i < 400 && wcount != 100; i++) tick();
    info = rnd_info();
    L1A_WRT_EN = 1'b1; L1A_INFO = info;
    tick();
    for (int i = 0; i < 40 && dat_q.size() < 8; i++) tick();
    n_chk++; if (hdr_q.size() != 1) begin n_fail++; $display("FAIL basic_hdr_count got %0d exp 1", hdr_q.size()); end
    if (hdr_q.size() > 0) begin
      hc = hdr_q[0].cyc;
      n_chk++; if (hdr_q[0].info !== info) begin n_fail++; $display("FAIL basic_hdr_info got %h exp %h", hdr_q[0].info, info); end
      n_chk++; if (hc - l1a_cyc != 2) begin n_fail++; $display("FAIL basic_hdr_latency got %0d exp 2", hc - l1a_cyc); end
      n_chk++; if (dat_q.size() != 8) begin n_fail++; $display("FAIL basic_word_count got %0d exp 8", dat_q.size()); end
      for (int k = 0; k < dat_q.size() && k < 8; k++) begin
        n_chk++; if (dat_q[k].rdata !== exp_word(96 + k, dat_q[k].w)) begin
          n_fail++; $display("FAIL basic_word%0d got %h exp %h", k, dat_q[k].rdata, exp_word(96 + k, dat_q[k].w)); end
        n_chk++; if (dat_q[k].cyc != hc + 3 + k) begin
          n_fail++; $display("FAIL basic_word%0d_cycle got %0d exp %0d", k, dat_q[k].cyc, hc + 3 + k); end
      end
    end
    repeat (4) tick();
    hdr_q.delete(); dat_q.delete();
  endtask

  task automatic test_hdr_only();
    logic [INFO_W-1:0] info [3];
    SAMP_MAX = '0;
    for (int i = 0; i < 3; i++) begin
      info[i] = rnd_info();
      L1A_WRT_EN = 1'b1; L1A_INFO = info[i];
      tick();
    end
    for (int i = 0; i < 30 && hdr_q.size() < 3; i++) tick();
    repeat (5) tick();
    n_chk++; if (hdr_q.size() != 3) begin n_fail++; $display("FAIL hdronly_count got %0d exp 3", hdr_q.size()); end
    for (int i = 0; i < 3 && i < hdr_q.size(); i++) begin
      n_chk++; if (hdr_q[i].info !== info[i]) begin n_fail++; $display("FAIL hdronly_info%0d got %h exp %h", i, hdr_q[i].info, info[i]); end
    end
    n_chk++; if (dat_q.size() != 0) begin n_fail++; $display("FAIL hdronly_no_data got %0d exp 0", dat_q.size()); end
    n_chk++; if (L1A_PEND !== '0) begin n_fail++; $display("FAIL hdronly_pend got %0d exp 0", L1A_PEND); end
    hdr_q.delete(); dat_q.delete();
  endtask

  task automatic test_overflow();
    logic [INFO_W-1:0] info [17];
    int start0;
    SAMP_MAX = '0; EVT_BUF_AFL = 1'b1;
    repeat (2) tick();
    start0 = wcount - int'(PRE_SAMP);
    for (int i = 0; i < 17; i++) begin
      info[i] = rnd_info();
      L1A_WRT_EN = 1'b1; L1A_INFO = info[i];
      tick();
    end
    repeat (3) tick();
    n_chk++; if (L1A_PEND !== 5'd16) begin n_fail++; $display("FAIL ovf_pend got %0d exp 16", L1A_PEND); end
    n_chk++; if (L1A_DROP !== 8'd1) begin n_fail++; $display("FAIL ovf_drop got %0d exp 1", L1A_DROP); end
    n_chk++; if (RING_CNT !== 13'(wcount - start0)) begin n_fail++; $display("FAIL ovf_ring_cnt got %0d exp %0d", RING_CNT, 13'(wcount - start0)); end
    n_chk++; if (hdr_q.size() != 0) begin n_fail++; $display("FAIL ovf_stalled got %0d exp 0", hdr_q.size()); end
    EVT_BUF_AFL = 1'b0;
    for (int i = 0; i < 100 && hdr_q.size() < 16; i++) tick();
    repeat (5) tick();
    n_chk++; if (hdr_q.size() != 16) begin n_fail++; $display("FAIL ovf_hdr_count got %0d exp 16", hdr_q.size()); end
    for (int i = 0; i < 16 && i < hdr_q.size(); i++) begin
      n_chk++; if (hdr_q[i].info !== info[i]) begin n_fail++; $display("FAIL ovf_hdr%0d got %h exp %h", i, hdr_q[i].info, info[i]); end
    end
    n_chk++; if (L1A_PEND !== '0) begin n_fail++; $display("FAIL ovf_pend_after got %0d exp 0", L1A_PEND); end
    hdr_q.delete(); dat_q.delete();
  endtask

  task automatic test_afl_hold();
    int start, nb, np, n_ovr;
    logic [AW:0] ecnt;
    PRE_SAMP = '0; SAMP_MAX = 7'd64;
    start = wcount;
    L1A_WRT_EN = 1'b1; L1A_INFO = rnd_info();
    tick();
    for (int i = 0; i < 20 && hdr_q.size() < 1; i++) tick();
    repeat (5) tick();
    nb = dat_q.size();
    EVT_BUF_AFL = 1'b1;
    repeat (4) tick();
    np = dat_q.size();
    n_chk++; if (np - nb > 2) begin n_fail++; $display("FAIL hold_inflight got %0d exp <=2", np - nb); end
    for (int i = 1; i <= 5000; i++) begin
      tick();
      if (i % 500 == 0) begin
        ecnt = 13'(wcount - (start + np));
        n_chk++; if (RING_CNT !== ecnt) begin n_fail++; $display("FAIL hold_ring_cnt@%0d got %0d exp %0d", i, RING_CNT, ecnt); end
        n_chk++; if (WARN !== (int'(ecnt) > 3328)) begin n_fail++; $display("FAIL hold_warn@%0d got %b exp %b", i, WARN, int'(ecnt) > 3328); end
      end
    end
    n_chk++; if (dat_q.size() != np) begin n_fail++; $display("FAIL hold_no_push got %0d exp %0d", dat_q.size(), np); end
    EVT_BUF_AFL = 1'b0;
    for (int i = 0; i < 200 && dat_q.size() < 64; i++) tick();
    repeat (4) tick();
    n_chk++; if (dat_q.size() != 64) begin n_fail++; $display("FAIL hold_word_count got %0d exp 64", dat_q.size()); end
    n_ovr = 0;
    for (int k = 0; k < dat_q.size() && k < 64; k++) begin
      n_chk++; if (dat_q[k].rdata !== exp_word(start + k, dat_q[k].w)) begin
        n_fail++; $display("FAIL hold_word%0d got %h exp %h", k, dat_q[k].rdata, exp_word(start + k, dat_q[k].w)); end
      if (dat_q[k].rdata[TAG_W+DW]) n_ovr++;
    end
    n_chk++; if (n_ovr == 0) begin n_fail++; $display("FAIL hold_ovr_words got 0 exp >0"); end
    n_chk++; if (OVERRUN !== 1'b1) begin n_fail++; $display("FAIL hold_overrun got %b exp 1", OVERRUN); end
    n_chk++; if (RING_CNT !== '0) begin n_fail++; $display("FAIL hold_idle_cnt got %0d exp 0", RING_CNT); end
    hdr_q.delete(); dat_q.delete();
  endtask

  task automatic test_wrap();
    logic [INFO_W-1:0] info;
    int start;
    PRE_SAMP = 12'd4; SAMP_MAX = 7'd4;
    for (int i = 0; i < 9000 && (wcount % 8192) != 2; i++) tick();
    start = wcount - 4;
    info = rnd_info();
    L1A_WRT_EN = 1'b1; L1A_INFO = info;
    tick();
    for (int i = 0; i < 30 && dat_q.size() < 4; i++) tick();
    n_chk++; if (hdr_q.size() != 1 || hdr_q[0].info !== info) begin n_fail++; $display("FAIL wrap_hdr got %0d headers exp 1 with info %h", hdr_q.size(), info); end
    n_chk++; if (dat_q.size() != 4) begin n_fail++; $display("FAIL wrap_word_count got %0d exp 4", dat_q.size()); end
    for (int k = 0; k < dat_q.size() && k < 4; k++) begin
      n_chk++; if (dat_q[k].rdata !== {1'b0, hist[start + k]}) begin
        n_fail++; $display("FAIL wrap_word%0d got %h exp %h", k, dat_q[k].rdata, {1'b0, hist[start + k]}); end
    end
    repeat (4) tick();
    hdr_q.delete(); dat_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [INFO_W-1:0] info;
    int start;
    PRE_SAMP = 12'd4; SAMP_MAX = 7'd32;
    L1A_WRT_EN = 1'b1; L1A_INFO = rnd_info();
    tick();
    for (int i = 0; i < 20 && hdr_q.size() < 1; i++) tick();
    L1A_WRT_EN = 1'b1; L1A_INFO = rnd_info();
    tick();
    L1A_WRT_EN = 1'b1; L1A_INFO = rnd_info();
    tick();
    tick();
    n_chk++; if (L1A_PEND !== 5'd2) begin n_fail++; $display("FAIL rmid_pend_before got %0d exp 2", L1A_PEND); end
    RST_RESYNC = 1'b1;
    tick();
    RST_RESYNC = 1'b0;
    n_chk++; if (DATA_PUSH !== 1'b0) begin n_fail++; $display("FAIL rmid_data_push got %b exp 0", DATA_PUSH); end
    n_chk++; if (L1A_EVT_PUSH !== 1'b0) begin n_fail++; $display("FAIL rmid_evt_push got %b exp 0", L1A_EVT_PUSH); end
    n_chk++; if (RDATA !== '0) begin n_fail++; $display("FAIL rmid_rdata got %h exp 0", RDATA); end
    n_chk++; if (RING_CNT !== '0) begin n_fail++; $display("FAIL rmid_ring_cnt got %0d exp 0", RING_CNT); end
    n_chk++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL rmid_overrun got %b exp 0", OVERRUN); end
    n_chk++; if (L1A_DROP !== '0) begin n_fail++; $display("FAIL rmid_drop got %0d exp 0", L1A_DROP); end
    n_chk++; if (L1A_PEND !== '0) begin n_fail++; $display("FAIL rmid_pend got %0d exp 0", L1A_PEND); end
    hdr_q.delete(); dat_q.delete();
    repeat (40) tick();
    n_chk++; if (hdr_q.size() + dat_q.size() != 0) begin n_fail++; $display("FAIL rmid_quiet got %0d pushes exp 0", hdr_q.size() + dat_q.size()); end
    SAMP_MAX = 7'd4;
    start = wcount - 4;
    info = rnd_info();
    L1A_WRT_EN = 1'b1; L1A_INFO = info;
    tick();
    for (int i = 0; i < 30 && dat_q.size() < 4; i++) tick();
    n_chk++; if (hdr_q.size() != 1 || hdr_q[0].info !== info) begin n_fail++; $display("FAIL rmid_new_hdr got %0d headers exp 1 with info %h", hdr_q.size(), info); end
    n_chk++; if (dat_q.size() != 4) begin n_fail++; $display("FAIL rmid_word_count got %0d exp 4", dat_q.size()); end
    for (int k = 0; k < dat_q.size() && k < 4; k++) begin
      n_chk++; if (dat_q[k].rdata !== exp_word(start + k, dat_q[k].w)) begin
        n_fail++; $display("FAIL rmid_word%0d got %h exp %h", k, dat_q[k].rdata, exp_word(start + k, dat_q[k].w)); end
    end
  endtask

  initial begin
    RST_RESYNC = 1'b1; WREN = 1'b0; WDATA = '0; WTAG = '0; L1A_WRT_EN = 1'b0;
    L1A_INFO = '0; EVT_BUF_AFL = 1'b0; SAMP_MAX = '0; PRE_SAMP = '0;
    test_reset();
    test_basic();
    test_hdr_only();
    test_overflow();
    test_afl_hold();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
